cache_bank_scheduler: RTL and testbench

CACHE_BANK_SCHEDULER -- requirements
Module: cache_bank_scheduler

---
 rtl/cache_bank_scheduler.sv | 158 +++++++++++++++
 tb/tb_cache_bank_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bank_scheduler.sv
// Schedules queued writes and 4-port reads onto one cache bank RAM.
// Reads issue only when the write queue is empty, so a read always sees every earlier-accepted write.
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module cache_bank_scheduler #(
    parameter int unsigned ADR      = `CACHE_BANK_ADDRESS_WIDTH,
    parameter int unsigned DAT      = `DATA_WIDTH,
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [ADR-1:0] wr_addr,
    input  logic [DAT-1:0] wr_data,
    input  logic           rd_valid,
    output logic           rd_ready,
    input  logic [ADR-1:0] rd_addr_0,
    input  logic [ADR-1:0] rd_addr_1,
    input  logic [ADR-1:0] rd_addr_2,
    input  logic [ADR-1:0] rd_addr_3,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DAT-1:0] rsp_data_0,
    output logic [DAT-1:0] rsp_data_1,
    output logic [DAT-1:0] rsp_data_2,
    output logic [DAT-1:0] rsp_data_3,
    output logic [3:0]     rsp_lineValid,
    output logic           ram_writeEnable,
    output logic           ram_readEnable,
    output logic [ADR-1:0] ram_writeAddr,
    output logic [DAT-1:0] ram_dataIn,
    output logic [ADR-1:0] ram_readAddr_0,
    output logic [ADR-1:0] ram_readAddr_1,
    output logic [ADR-1:0] ram_readAddr_2,
    output logic [ADR-1:0] ram_readAddr_3,
    input  logic [DAT-1:0] ram_dOut_0,
    input  logic [DAT-1:0] ram_dOut_1,
    input  logic [DAT-1:0] ram_dOut_2,
    input  logic [DAT-1:0] ram_dOut_3,
    input  logic [3:0]     ram_writtenTo
);

    localparam int unsigned PW = $clog2(WQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_ISSUE = 2'd1;
    localparam logic [1:0] READ_WAIT  = 2'd2;
    localparam logic [1:0] RESP       = 2'd3;

    logic [1:0]     state;
    logic [1:0]     nextState;
    logic [ADR-1:0] queueAddr [WQ_DEPTH];
    logic [DAT-1:0] queueData [WQ_DEPTH];
    logic [PW-1:0]  headPtr;
    logic [PW-1:0]  tailPtr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           readAccept;

    // wr_ready looks only at the registered count, so a full queue never passes through on a pop
    assign wr_ready   = (count < CW'(WQ_DEPTH));
    assign rd_ready   = (state == IDLE) && (count == CW'(0)) && !wr_valid;
    assign push       = wr_valid && wr_ready;
    assign pop        = (state == IDLE) && (count != CW'(0));
    assign readAccept = rd_valid && rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (readAccept) nextState = READ_ISSUE;
            READ_ISSUE: nextState = READ_WAIT;
            READ_WAIT:  nextState = RESP;
            RESP:       if (rsp_ready) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // Queue storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            queueAddr[tailPtr] <= wr_addr;
            queueData[tailPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + PW'(1);
            if (pop)  headPtr <= headPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // RAM command and response registers; addresses/data hold when not enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_writeEnable <= 1'b0;
            ram_readEnable  <= 1'b0;
            ram_writeAddr   <= '0;
            ram_dataIn      <= '0;
            ram_readAddr_0  <= '0;
            ram_readAddr_1  <= '0;
            ram_readAddr_2  <= '0;
            ram_readAddr_3  <= '0;
            rsp_valid       <= 1'b0;
            rsp_data_0      <= '0;
            rsp_data_1      <= '0;
            rsp_data_2      <= '0;
            rsp_data_3      <= '0;
            rsp_lineValid   <= '0;
        end else begin
            ram_writeEnable <= pop;
            ram_readEnable  <= readAccept;
            if (pop) begin
                ram_writeAddr <= queueAddr[headPtr];
                ram_dataIn    <= queueData[headPtr];
            end
            if (readAccept) begin
                ram_readAddr_0 <= rd_addr_0;
                ram_readAddr_1 <= rd_addr_1;
                ram_readAddr_2 <= rd_addr_2;
                ram_readAddr_3 <= rd_addr_3;
            end
            if (state == READ_WAIT) begin
                rsp_valid     <= 1'b1;
                rsp_data_0    <= ram_dOut_0;
                rsp_data_1    <= ram_dOut_1;
                rsp_data_2    <= ram_dOut_2;
                rsp_data_3    <= ram_dOut_3;
                rsp_lineValid <= ~ram_writtenTo;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_bank_scheduler.sv
// Directed bench for cache_bank_scheduler with a behavioural bank RAM.
// Table-driven cycle vectors plus hand sequences for full queue, backpressure and mid-read reset.
module tb_cache_bank_scheduler;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data_0, rsp_data_1, rsp_data_2, rsp_data_3;
    logic [3:0]  rsp_lineValid;
    logic        ram_writeEnable;
    logic        ram_readEnable;
    logic [7:0]  ram_writeAddr;
    logic [31:0] ram_dataIn;
    logic [7:0]  ram_readAddr_0, ram_readAddr_1, ram_readAddr_2, ram_readAddr_3;
    logic [31:0] ram_dOut_0, ram_dOut_1, ram_dOut_2, ram_dOut_3;
    logic [3:0]  ram_writtenTo;

    int total = 0;
    int bad   = 0;

    cache_bank_scheduler #(.ADR(8), .DAT(32), .WQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2), .rsp_data_3(rsp_data_3),
        .rsp_lineValid(rsp_lineValid),
        .ram_writeEnable(ram_writeEnable), .ram_readEnable(ram_readEnable),
        .ram_writeAddr(ram_writeAddr), .ram_dataIn(ram_dataIn),
        .ram_readAddr_0(ram_readAddr_0), .ram_readAddr_1(ram_readAddr_1),
        .ram_readAddr_2(ram_readAddr_2), .ram_readAddr_3(ram_readAddr_3),
        .ram_dOut_0(ram_dOut_0), .ram_dOut_1(ram_dOut_1), .ram_dOut_2(ram_dOut_2), .ram_dOut_3(ram_dOut_3),
        .ram_writtenTo(ram_writtenTo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank RAM: one-cycle read latency, written flags cleared by reset
    logic [31:0] ramMem [256];
    logic        ramWritten [256];
    initial for (int i = 0; i < 256; i++) ramMem[i] = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ramWritten[i] <= 1'b0;
            ram_dOut_0 <= '0; ram_dOut_1 <= '0; ram_dOut_2 <= '0; ram_dOut_3 <= '0;
            ram_writtenTo <= 4'hF;
        end else begin
            if (ram_writeEnable) begin
                ramMem[ram_writeAddr]     <= ram_dataIn;
                ramWritten[ram_writeAddr] <= 1'b1;
            end
            if (ram_readEnable) begin
                ram_dOut_0 <= ramMem[ram_readAddr_0];
                ram_dOut_1 <= ramMem[ram_readAddr_1];
                ram_dOut_2 <= ramMem[ram_readAddr_2];
                ram_dOut_3 <= ramMem[ram_readAddr_3];
                ram_writtenTo <= {!ramWritten[ram_readAddr_3], !ramWritten[ram_readAddr_2],
                                  !ramWritten[ram_readAddr_1], !ramWritten[ram_readAddr_0]};
            end
        end
    end

    logic [7:0]  capAddr [$];
    logic [31:0] capData [$];
    always @(posedge clk) begin
        if (!reset && ram_writeEnable) begin
            capAddr.push_back(ram_writeAddr);
            capData.push_back(ram_dataIn);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (ram_writeEnable && ram_readEnable) begin
                bad++;
                $display("FAIL enable_exclusive: actual we=%0b re=%0b required not both 1 at %0t",
                         ram_writeEnable, ram_readEnable, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wv;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [7:0]  ra;
        logic [7:0]  ra1;
        logic        rr;
        logic        eWr;
        logic        eRd;
        logic        eWe;
        logic        eRe;
        logic        eRv;
        logic        chkData;
        logic [31:0] eD0;
        logic [3:0]  eLv;
    } vec_t;

    vec_t vecs [10];

    // Drive at posedge+1, check handshakes at +2, check registered outputs at next posedge+1
    task automatic applyVec(input int idx, input vec_t v);
        wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd;
        rd_valid = v.rv; rd_addr_0 = v.ra; rd_addr_1 = v.ra1; rd_addr_2 = v.ra; rd_addr_3 = v.ra;
        rsp_ready = v.rr;
        #1;
        chk($sformatf("vec%0d_wr_ready", idx), 32'(wr_ready), 32'(v.eWr));
        chk($sformatf("vec%0d_rd_ready", idx), 32'(rd_ready), 32'(v.eRd));
        @(posedge clk); #1;
        chk($sformatf("vec%0d_ram_writeEnable", idx), 32'(ram_writeEnable), 32'(v.eWe));
        chk($sformatf("vec%0d_ram_readEnable", idx), 32'(ram_readEnable), 32'(v.eRe));
        chk($sformatf("vec%0d_rsp_valid", idx), 32'(rsp_valid), 32'(v.eRv));
        if (v.chkData) begin
            chk($sformatf("vec%0d_rsp_data_0", idx), rsp_data_0, v.eD0);
            chk($sformatf("vec%0d_rsp_lineValid", idx), 32'(rsp_lineValid), 32'(v.eLv));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wv  wa     wd         rv  ra     ra1    rr   eWr  eRd  eWe  eRe  eRv  chk  eD0        eLv
        vecs[0] = '{1'b1, 8'd5, 32'hA5, 1'b1, 8'd5, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[1] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd5, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[2] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd5, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[3] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[4] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5, 4'hF};
        vecs[5] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5, 4'hF};
        vecs[6] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd5, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[7] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};
        vecs[8] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5, 4'b1101};
        vecs[9] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0};

        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr_0 = '0; rd_addr_1 = '0; rd_addr_2 = '0; rd_addr_3 = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ram_writeEnable", 32'(ram_writeEnable), 32'h0);
        chk("reset_ram_readEnable", 32'(ram_readEnable), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data_3", rsp_data_3, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_reset_wr_ready", 32'(wr_ready), 32'h1);
        chk("post_reset_rd_ready", 32'(rd_ready), 32'h1);
        @(posedge clk); #1;

        // Write then read through the table; includes the simultaneous wr/rd case
        for (int i = 0; i < 10; i++) applyVec(i, vecs[i]);
        chk("held_ram_readAddr_1", 32'(ram_readAddr_1), 32'h2);
        chk("held_ram_writeAddr", 32'(ram_writeAddr), 32'h5);
        chk("seqA_write_count", 32'(capAddr.size()), 32'h1);
        if (capAddr.size() == 1) begin
            chk("seqA_write_addr", 32'(capAddr[0]), 32'h5);
            chk("seqA_write_data", capData[0], 32'hA5);
        end

        // Hold a response with rsp_ready low while filling the queue
        capAddr.delete(); capData.delete();
        rd_valid = 1'b1; rd_addr_0 = 8'd7; rd_addr_1 = 8'd7; rd_addr_2 = 8'd7; rd_addr_3 = 8'd7;
        rsp_ready = 1'b0;
        #1;
        chk("seqB_rd_ready", 32'(rd_ready), 32'h1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        chk("seqB_ram_readEnable", 32'(ram_readEnable), 32'h1);
        @(posedge clk); #1;
        chk("seqB_rsp_valid_early", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        chk("seqB_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("seqB_lineValid", 32'(rsp_lineValid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(16 + i); wr_data = 32'h100 + 32'(i);
            #1;
            chk($sformatf("seqB_wr_ready_%0d", i), 32'(wr_ready), (i < 4) ? 32'h1 : 32'h0);
            chk($sformatf("seqB_rd_ready_%0d", i), 32'(rd_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("seqB_hold_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("seqB_hold_rsp_data_%0d", i), rsp_data_0, 32'h0);
            chk($sformatf("seqB_hold_we_%0d", i), 32'(ram_writeEnable), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("seqB_full_wr_ready", 32'(wr_ready), 32'h0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("seqB_rsp_released", 32'(rsp_valid), 32'h0);
        #1;
        chk("seqB_pop_cycle_wr_ready", 32'(wr_ready), 32'h0);
        @(posedge clk); #1;
        chk("seqB_drain_start_we", 32'(ram_writeEnable), 32'h1);
        #1;
        chk("seqB_after_pop_wr_ready", 32'(wr_ready), 32'h1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("seqB_write_count", 32'(capAddr.size()), 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (i < capAddr.size()) begin
                chk($sformatf("seqB_order_addr_%0d", i), 32'(capAddr[i]), 32'(16 + i));
                chk($sformatf("seqB_order_data_%0d", i), capData[i], 32'h100 + 32'(i));
            end
        end

        // Reset in READ_WAIT with a write queued and another pending
        rd_valid = 1'b1; rd_addr_0 = 8'd9; rd_addr_1 = 8'd9; rd_addr_2 = 8'd9; rd_addr_3 = 8'd9;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'd30; wr_data = 32'h300;
        @(posedge clk); #1;
        wr_addr = 8'd31; wr_data = 32'h301;
        #2;
        reset = 1'b1;
        #1;
        chk("seqC_ram_writeEnable", 32'(ram_writeEnable), 32'h0);
        chk("seqC_ram_readEnable", 32'(ram_readEnable), 32'h0);
        chk("seqC_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("seqC_ram_writeAddr", 32'(ram_writeAddr), 32'h0);
        chk("seqC_ram_readAddr_0", 32'(ram_readAddr_0), 32'h0);
        chk("seqC_rsp_lineValid", 32'(rsp_lineValid), 32'h0);
        chk("seqC_wr_ready", 32'(wr_ready), 32'h1);
        wr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        capAddr.delete(); capData.delete();
        #1;
        chk("seqC_release_wr_ready", 32'(wr_ready), 32'h1);
        chk("seqC_release_rd_ready", 32'(rd_ready), 32'h1);
        wr_valid = 1'b1;
        #1;
        chk("seqC_release_rd_ready_wv", 32'(rd_ready), 32'h0);
        wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("seqC_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
        end
        chk("seqC_no_drain", 32'(capAddr.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
